// File: rtl/rvv_wb_collector.sv
`default_nettype none
// ============================================================================
//  Module   : rvv_wb_collector
//  Purpose  : Vector write-back collector. Gathers per-beat ALU lane results
//             into a full VLEN destination image seeded from old_vd, applying
//             tail-undisturbed (and optionally mask-undisturbed) byte enables,
//             then hands the image to the vreg file via a valid/ready port.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, resetn          clock, synchronous active-low reset
//    start                begin one destination register (IDLE only)
//    vd_addr/vl/vsew      destination, element count, element width code
//    old_vd               prior vd contents (tail/mask source)
//    nb_lanes             log2 of lanes valid this beat
//    res_valid/res_ready  lane result beat handshake
//    res_index            bit offset in vd of lane 0 of the beat
//    res_data             lane i in bits [i*64 +: 2^LANE_WIDTH]
//    res_last             final beat of the register
//    wb_valid/wb_ready    register-file write handshake
//    wb_addr/wb_data      write destination and image
//    done                 one-cycle pulse when the register is retired
//  Optional feature macro: RVV_WB_MASK_EN adds vm and v0_mask inputs;
//    inactive elements (vm==0 and v0_mask bit clear) keep old_vd.
// ============================================================================
module rvv_wb_collector #(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 3,
    parameter int NLANES     = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [4:0]             vd_addr,
    input  logic [9:0]             vl,
    input  logic [2:0]             vsew,
    input  logic [VLEN-1:0]        old_vd,
`ifdef RVV_WB_MASK_EN
    input  logic                   vm,
    input  logic [VLEN-1:0]        v0_mask,
`endif
    input  logic [1:0]             nb_lanes,
    input  logic                   res_valid,
    output logic                   res_ready,
    input  logic [9:0]             res_index,
    input  logic [NLANES*64-1:0]   res_data,
    input  logic                   res_last,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [4:0]             wb_addr,
    output logic [VLEN-1:0]        wb_data,
    output logic                   done
);

    localparam int C_LW     = 1 << LANE_WIDTH;
    localparam int C_NBYTES = VLEN / 8;
    localparam int C_IW     = $clog2(VLEN);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [VLEN-1:0] r_buf;
    logic [VLEN-1:0] w_merged;
    logic [4:0]      r_addr;
    logic [9:0]      r_vl;
    logic [1:0]      r_vsew;
    logic            r_done;
`ifdef RVV_WB_MASK_EN
    logic            r_vm;
    logic [VLEN-1:0] r_v0;
`endif

    // Element widths above 64 bits are not defined; fold them onto 64.
    logic [1:0] w_vsew_clamped;
    assign w_vsew_clamped = (vsew > 3'd3) ? 2'd3 : vsew[1:0];

    // ------------------------------------------------------------------
    // Beat merge: for every buffer byte, find the lane covering it and
    // take that lane's byte when the byte is active. Higher-numbered lanes
    // are visited last so they win any overlap.
    // ------------------------------------------------------------------
    always_comb begin : merge
        logic [63:0] lane_word;
        logic [63:0] shifted;
        int          lane_base;
        int          elem;
        logic        byte_en;
        w_merged  = r_buf;
        lane_word = '0;
        shifted   = '0;
        lane_base = 0;
        elem      = 0;
        byte_en   = 1'b0;
        for (int b = 0; b < C_NBYTES; b++) begin
            elem    = (b * 8) >> (int'(r_vsew) + 3);
            byte_en = (elem < int'(r_vl));
`ifdef RVV_WB_MASK_EN
            byte_en = byte_en && (r_vm || r_v0[elem[C_IW-1:0]]);
`endif
            if (byte_en) begin
                for (int i = 0; i < NLANES; i++) begin
                    lane_base = int'(res_index) + i * C_LW;
                    if ((i < (1 << nb_lanes)) && (b * 8 >= lane_base) &&
                        (b * 8 < lane_base + C_LW)) begin
                        lane_word = res_data[i*64 +: 64];
                        shifted   = lane_word >> (b * 8 - lane_base);
                        w_merged[b*8 +: 8] = shifted[7:0];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic. vl==0 retires immediately without a write.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && (vl != 10'd0)) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (res_valid && res_last) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wb_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        res_ready = (r_state == S_COLLECT);
        wb_valid  = (r_state == S_WRITE);
    end

    assign wb_addr = r_addr;
    assign wb_data = r_buf;
    assign done    = r_done;

    // ------------------------------------------------------------------
    // Datapath registers. The buffer is frozen in WRITE so wb_data stays
    // stable while the register file back-pressures.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_buf  <= '0;
            r_addr <= '0;
            r_vl   <= '0;
            r_vsew <= '0;
            r_done <= 1'b0;
`ifdef RVV_WB_MASK_EN
            r_vm   <= 1'b1;
            r_v0   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_buf  <= old_vd;
                        r_addr <= vd_addr;
                        r_vl   <= vl;
                        r_vsew <= w_vsew_clamped;
`ifdef RVV_WB_MASK_EN
                        r_vm   <= vm;
                        r_v0   <= v0_mask;
`endif
                        if (vl == 10'd0) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (res_valid) begin
                        r_buf <= w_merged;
                    end
                end
                S_WRITE: begin
                    if (wb_ready) begin
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rvv_wb_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rvv_wb_collector
//  Purpose  : Self-checking bench for rvv_wb_collector. Two instances (8-bit
//             and 32-bit lanes) share all stimulus; each is compared against
//             a byte-array reference model of the write-back rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rvv_wb_collector;

    localparam int VLEN   = 128;
    localparam int NLANES = 4;
    localparam int NB     = VLEN / 8;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 start;
    logic [4:0]           vd_addr;
    logic [9:0]           vl;
    logic [2:0]           vsew;
    logic [VLEN-1:0]      old_vd;
    logic                 vm;
    logic [VLEN-1:0]      v0_mask;
    logic [1:0]           nb_lanes;
    logic                 res_valid;
    logic [9:0]           res_index;
    logic [NLANES*64-1:0] res_data;
    logic                 res_last;
    logic                 wb_ready;

    logic                 rdy8, wbv8, done8;
    logic [4:0]           addr8;
    logic [VLEN-1:0]      data8;
    logic                 rdy32, wbv32, done32;
    logic [4:0]           addr32;
    logic [VLEN-1:0]      data32;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rvv_wb_collector #(.VLEN(VLEN), .LANE_WIDTH(3), .NLANES(NLANES)) dut8 (
        .clk(clk), .resetn(resetn), .start(start), .vd_addr(vd_addr),
        .vl(vl), .vsew(vsew), .old_vd(old_vd),
`ifdef RVV_WB_MASK_EN
        .vm(vm), .v0_mask(v0_mask),
`endif
        .nb_lanes(nb_lanes), .res_valid(res_valid), .res_ready(rdy8),
        .res_index(res_index), .res_data(res_data), .res_last(res_last),
        .wb_valid(wbv8), .wb_ready(wb_ready), .wb_addr(addr8),
        .wb_data(data8), .done(done8)
    );

    rvv_wb_collector #(.VLEN(VLEN), .LANE_WIDTH(5), .NLANES(NLANES)) dut32 (
        .clk(clk), .resetn(resetn), .start(start), .vd_addr(vd_addr),
        .vl(vl), .vsew(vsew), .old_vd(old_vd),
`ifdef RVV_WB_MASK_EN
        .vm(vm), .v0_mask(v0_mask),
`endif
        .nb_lanes(nb_lanes), .res_valid(res_valid), .res_ready(rdy32),
        .res_index(res_index), .res_data(res_data), .res_last(res_last),
        .wb_valid(wbv32), .wb_ready(wb_ready), .wb_addr(addr32),
        .wb_data(data32), .done(done32)
    );

    // ---------------- reference model: one byte image per instance -------
    logic [7:0] mdl [2][NB];
    int         m_vl;
    int         m_sew;
    logic       m_vm;
    logic [VLEN-1:0] m_v0;
    logic [4:0] m_addr;

    function automatic logic [VLEN-1:0] image(input int k);
        logic [VLEN-1:0] r;
        for (int b = 0; b < NB; b++) r[b*8 +: 8] = mdl[k][b];
        return r;
    endfunction

    // Walk each valid lane byte by byte; a byte lands only if it is inside
    // the register, its element is below vl, and it is not masked off.
    task automatic model_beat(input int k, input int lwbits, input logic [1:0] nbl,
                              input logic [9:0] idx, input logic [NLANES*64-1:0] d);
        int p;
        int e;
        for (int i = 0; i < (1 << nbl) && i < NLANES; i++) begin
            for (int j = 0; j < lwbits / 8; j++) begin
                p = int'(idx) + i * lwbits + j * 8;
                e = p / (8 << m_sew);
                if (p < VLEN && e < m_vl && (m_vm || m_v0[e]))
                    mdl[k][p/8] = d[i*64 + j*8 +: 8];
            end
        end
    endtask

    // ---------------- helpers ---------------------------------------------
    task automatic chk(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] a, input logic [9:0] l, input logic [2:0] s,
                            input logic [VLEN-1:0] old);
        start = 1'b1; vd_addr = a; vl = l; vsew = s; old_vd = old;
        tick();
        start = 1'b0;
        for (int b = 0; b < NB; b++) begin
            mdl[0][b] = old[b*8 +: 8];
            mdl[1][b] = old[b*8 +: 8];
        end
        m_vl = int'(l); m_sew = (s > 3'd3) ? 3 : int'(s);
        m_vm = vm; m_v0 = v0_mask; m_addr = a;
    endtask

    task automatic do_beat(input logic [1:0] nbl, input logic [9:0] idx,
                           input logic [NLANES*64-1:0] d, input logic last);
        chk("ready8_collect", {127'b0, rdy8}, 1);
        chk("ready32_collect", {127'b0, rdy32}, 1);
        nb_lanes = nbl; res_index = idx; res_data = d; res_last = last; res_valid = 1'b1;
        tick();
        res_valid = 1'b0; res_last = 1'b0;
        model_beat(0, 8, nbl, idx, d);
        model_beat(1, 32, nbl, idx, d);
    endtask

    function automatic logic [NLANES*64-1:0] rnd_data();
        logic [NLANES*64-1:0] r;
        for (int w = 0; w < NLANES * 2; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Expects to be called right after the last beat; holds wb_ready low
    // for 'hold' cycles with junk res_valid, then completes the write.
    task automatic finish_write(input int hold);
        chk("wbv8_after_last", {127'b0, wbv8}, 1);
        chk("wbv32_after_last", {127'b0, wbv32}, 1);
        for (int c = 0; c < hold; c++) begin
            res_valid = 1'b1; res_data = rnd_data(); res_index = 10'd0; nb_lanes = 2'd2;
            chk("rdy8_write", {127'b0, rdy8}, 0);
            chk("data8_stable", data8, image(0));
            chk("data32_stable", data32, image(1));
            tick();
        end
        res_valid = 1'b0;
        chk("wbv8_hold", {127'b0, wbv8}, 1);
        chk("addr8", {123'b0, addr8}, {123'b0, m_addr});
        chk("addr32", {123'b0, addr32}, {123'b0, m_addr});
        chk("data8", data8, image(0));
        chk("data32", data32, image(1));
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("done8", {127'b0, done8}, 1);
        chk("done32", {127'b0, done32}, 1);
        chk("wbv8_retired", {127'b0, wbv8}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NLANES*64-1:0] d;
        int epr;
        int nbeats;

        resetn = 1'b0; start = 1'b0; vd_addr = '0; vl = '0; vsew = '0; old_vd = '0;
        vm = 1'b1; v0_mask = '0; nb_lanes = '0; res_valid = 1'b0; res_index = '0;
        res_data = '0; res_last = 1'b0; wb_ready = 1'b0;
        m_vm = 1'b1; m_v0 = '0; m_vl = 0; m_sew = 0; m_addr = '0;
        tick(); tick();

        // Reset state
        chk("rst_ready", {127'b0, rdy8 | rdy32}, 0);
        chk("rst_wbv", {127'b0, wbv8 | wbv32}, 0);
        chk("rst_addr", {123'b0, addr8 | addr32}, 0);
        chk("rst_data8", data8, 0);
        chk("rst_data32", data32, 0);
        chk("rst_done", {127'b0, done8 | done32}, 0);
        resetn = 1'b1;
        tick();

        // Byte lanes over an all-FF register, single last beat
        do_start(5'd3, 10'd16, 3'd0, {VLEN{1'b1}});
        d = rnd_data();
        d[0 +: 64] = 64'h11; d[64 +: 64] = 64'h22; d[128 +: 64] = 64'h33; d[192 +: 64] = 64'h44;
        do_beat(2'd2, 10'd0, d, 1'b1);
        chk("tp1_data8_const", data8, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_44332211);
        finish_write(0);
        tick();
        chk("done8_pulse_end", {127'b0, done8}, 0);

        // 32-bit elements, vl=3: last element keeps old_vd (tail)
        do_start(5'd7, 10'd3, 3'd2, '0);
        for (int k = 0; k < 4; k++) begin
            d = rnd_data();
            d[31:0] = 32'hAAAAAAAA;
            do_beat(2'd0, 10'(k * 32), d, k == 3);
        end
        chk("tp2_data32_const", data32, 128'h00000000_AAAAAAAA_AAAAAAAA_AAAAAAAA);
        finish_write(5);
        tick();

        // vl==0: immediate done, no write
        do_start(5'd9, 10'd0, 3'd1, {VLEN{1'b1}});
        chk("vl0_done", {127'b0, done8 & done32}, 1);
        chk("vl0_ready", {127'b0, rdy8 | rdy32}, 0);
        chk("vl0_wbv", {127'b0, wbv8 | wbv32}, 0);
        tick();
        chk("vl0_done_low", {127'b0, done8 | done32}, 0);
        chk("vl0_ready_idle", {127'b0, rdy8 | rdy32}, 0);

        // Reset in the middle of COLLECT, then a fresh register
        do_start(5'd4, 10'd16, 3'd0, {$urandom, $urandom, $urandom, $urandom});
        do_beat(2'd2, 10'd0, rnd_data(), 1'b0);
        do_beat(2'd2, 10'd32, rnd_data(), 1'b0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("midrst_ready", {127'b0, rdy8 | rdy32}, 0);
        chk("midrst_wbv", {127'b0, wbv8 | wbv32}, 0);
        chk("midrst_data8", data8, 0);
        do_start(5'd5, 10'd16, 3'd0, {$urandom, $urandom, $urandom, $urandom});
        do_beat(2'd1, 10'd64, rnd_data(), 1'b1);
        finish_write(1);

`ifdef RVV_WB_MASK_EN
        // Masked write: only elements enabled in v0 take the result
        tick();
        vm = 1'b0; v0_mask = 128'h00FF;
        do_start(5'd2, 10'd16, 3'd0, '0);
        d = {NLANES*8{8'h5A}};
        for (int k = 0; k < 4; k++) do_beat(2'd2, 10'(k * 32), d, k == 3);
        chk("mask_data8_const", data8, 128'h0000000000000000_5A5A5A5A5A5A5A5A);
        chk("mask_data32_const", data32, 128'h0000000000000000_5A5A5A5A5A5A5A5A);
        finish_write(0);
        vm = 1'b1; v0_mask = '0;
`endif

        // Randomized registers; each new start lands in the done cycle
        for (int op = 0; op < 25; op++) begin
            vsew = 3'($urandom_range(0, 7));
            epr = VLEN / (8 << ((vsew > 3'd3) ? 3 : int'(vsew)));
            do_start(5'($urandom), 10'($urandom_range(1, epr + 2)), vsew,
                     {$urandom, $urandom, $urandom, $urandom});
            nbeats = $urandom_range(1, 6);
            for (int bt = 0; bt < nbeats; bt++) begin
                if ($urandom_range(0, 2) == 0) begin
                    res_valid = 1'b0;
                    tick();
                end
                do_beat(2'($urandom_range(0, 2)), 10'($urandom_range(0, (VLEN + 64) / 8) * 8),
                        rnd_data(), bt == nbeats - 1);
            end
            finish_write($urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvv_wb_collector.md
Name: rvv_wb_collector

Overview:
Write-back collector for the vector datapath: consumes per-beat lane results from the vector ALU lanes and assembles them into a full VLEN destination register image. Applies tail-undisturbed policy from vl/vsew at byte granularity, with optional v0 masking. Hands the finished image to the vector register file through a valid/ready write port. Sits between the ALU lanes and the vreg write port, mirroring the operand-slicing done on the read side.

Parameters:
VLEN, 128, vector register width in bits (multiple of 64).
LANE_WIDTH, 3, log2 of lane width in bits (3..6 → 8..64).
NLANES, 4, maximum lanes delivered per beat.

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
start  in  1  pulse: begin collecting one destination register
vd_addr  in  5  destination vreg number, captured on start
vl  in  10  active element count, captured on start
vsew  in  3  element width code 0..3 (8/16/32/64), captured on start
old_vd  in  VLEN  prior vd contents, captured on start (tail/mask source)
nb_lanes  in  2  2^nb_lanes lanes valid this beat (≤ NLANES)
res_valid  in  1  lane result beat valid
res_ready  out  1  collector accepts beat
res_index  in  10  bit offset in vd of lane 0 of this beat
res_data  in  NLANES*64  lane i result in bits [i*64 +: 2^LANE_WIDTH]
res_last  in  1  final beat of this register
wb_valid  out  1  write request valid
wb_ready  in  1  register file accepts write
wb_addr  out  5  destination vreg
wb_data  out  VLEN  assembled register image
done  out  1  one-cycle pulse when register retired

Behaviour:
- States: IDLE, COLLECT, WRITE. Reset (any state, mid-operation included) → IDLE; res_ready=0, wb_valid=0, wb_addr=0, wb_data=0, done=0, internal buffer cleared.
- IDLE: start=1 → capture vd_addr, vl, vsew; load buffer ← old_vd. If vl==0 → stay IDLE, done=1 next cycle, no write issued. Else → COLLECT.
- COLLECT: res_ready=1. Beat accepted when res_valid&res_ready. For lane i < 2^nb_lanes: lane offset o = res_index + i*2^LANE_WIDTH; bits [o +: 2^LANE_WIDTH] written into buffer byte by byte.
- Byte enable: byte at bit position p written iff p < VLEN and (p >> (vsew+3)) < vl; otherwise buffer byte keeps old_vd value (tail-undisturbed). Lanes wholly ≥ VLEN are dropped silently.
- Lanes narrower than a byte do not occur (LANE_WIDTH ≥ 3).
- Accepted beat with res_last=1 → WRITE on next cycle; that beat's data is included. Latency: last beat at cycle N → wb_valid=1 at N+1.
- WRITE: res_ready=0; wb_valid=1, wb_addr/wb_data stable until wb_ready. On wb_valid&wb_ready → IDLE, done=1 next cycle.
- start outside IDLE ignored. res_valid outside COLLECT ignored (res_ready=0).
- Two beats writing the same byte: later beat wins.
- vsew > 3: treated as 3.
- done and start in the same cycle: start honoured (IDLE already re-entered).

Optional Feature:
Macro RVV_WB_MASK_EN. When defined: extra inputs vm (1) and v0_mask (VLEN) captured on start; a byte is additionally suppressed when vm==0 and v0_mask[p >> (vsew+3)]==0 (mask-undisturbed, keeps old_vd). When undefined: ports absent, all active bodies written unconditionally.

Test Plan:
- VLEN=128, vsew=0, vl=16, old_vd=all 0xFF; one beat nb_lanes=2, res_index=0, lanes 0..3 = 0x11,0x22,0x33,0x44, res_last → wb_data bytes 0..3 = 11,22,33,44, bytes 4..15 = FF; wb_valid one cycle after beat.
- vsew=2, vl=3, old_vd=0; LANE_WIDTH=5, four beats of one lane each with 0xAAAAAAAA at res_index 0,32,64,96 → bits 0..95 = AA…, bits 96..127 = 0 (tail kept).
- start with vl=0 → no wb_valid, done pulses one cycle after start, res_ready stays 0.
- wb_ready held low 5 cycles in WRITE → wb_valid, wb_addr, wb_data stable; res_valid=1 during WRITE not accepted; done one cycle after wb_ready rises.
- resetn low during COLLECT after two beats → next cycle res_ready=0, wb_valid=0; new start with fresh old_vd yields no stale bytes.
- RVV_WB_MASK_EN, vsew=0, vl=16, vm=0, v0_mask=0x00FF, all lanes 0x5A, old_vd=0 → bytes 0..7 = 5A, bytes 8..15 = 00.
